// File: rtl/window_gather.sv
// window_gather: builds sliding 3x3 pixel windows from a raster stream and
// pairs each one with a serially loaded 3x3 kernel. The result is a 144-bit
// bundle for the MAC stage.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   w_valid/w_data/w_ready      weight byte input (9 bytes per frame)
//   in_valid/in_pixel/in_ready  pixel input, raster order
//   out_valid/out_ready         output handshake
//   out_data            {weights[71:0], window[71:0]}, byte k at [8k+7:8k]
//   out_last            final window of the frame (qualified by out_valid)
//   dbg_state           current FSM state (0 = LOAD_W, 1 = STREAM)
//
// Handshake: every stream transfers a byte/bundle on a rising edge where
// valid & ready are both high. Valid never depends on ready. out_data and
// out_last hold while out_valid & !out_ready.
module window_gather #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         w_valid,
  input  logic [7:0]   w_data,
  output logic         w_ready,
  input  logic         in_valid,
  input  logic [7:0]   in_pixel,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [143:0] out_data,
  output logic         out_last,
  output logic         dbg_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {LOAD_W = 1'b0, STREAM = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [3:0]    wcnt_q;

  logic [7:0] wt_q [9];
  // lb1 holds row r-1, lb2 holds row r-2, both indexed by column.
  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  // win_a/win_b are window columns c-2 and c-1 relative to the incoming pixel;
  // index 0 is the top row.
  logic [7:0] win_a [3];
  logic [7:0] win_b [3];
  logic [7:0] new_col [3];

  logic        w_acc, px_acc, produce;
  logic        col_last, row_last;
  logic [71:0] win_flat, wt_flat;

  assign w_acc    = w_valid & w_ready;
  assign px_acc   = in_valid & in_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign produce  = px_acc & (row_q >= RW'(2)) & (col_q >= CW'(2));
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    w_ready  = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_acc && wcnt_q == 4'd8) state_d = STREAM;
      end
      STREAM: begin
        in_ready = !out_valid || out_ready;
        if (px_acc && col_last && row_last) state_d = LOAD_W;
      end
      default: state_d = LOAD_W;
    endcase
  end

  // The new right-hand column comes straight from the line buffers plus the
  // pixel being accepted, so the window is complete in the acceptance cycle.
  always_comb begin
    new_col[0] = lb2[col_q];
    new_col[1] = lb1[col_q];
    new_col[2] = in_pixel;
    win_flat   = '0;
    wt_flat    = '0;
    for (int i = 0; i < 3; i++) begin
      win_flat[24*i +: 8]      = win_a[i];
      win_flat[24*i + 8 +: 8]  = win_b[i];
      win_flat[24*i + 16 +: 8] = new_col[i];
    end
    for (int k = 0; k < 9; k++) wt_flat[8*k +: 8] = wt_q[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_W;
      col_q   <= '0;
      row_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (w_acc) wcnt_q <= (wcnt_q == 4'd8) ? 4'd0 : wcnt_q + 4'd1;
      if (px_acc) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Data storage needs no reset: the r>=2 / c>=2 rule keeps stale bytes out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_acc) wt_q[wcnt_q] <= w_data;
      if (px_acc) begin
        lb2[col_q] <= lb1[col_q];
        lb1[col_q] <= in_pixel;
        for (int i = 0; i < 3; i++) begin
          win_a[i] <= win_b[i];
          win_b[i] <= new_col[i];
        end
      end
    end
  end

  // Single-entry output register. Weights are captured with the window, so a
  // pending bundle is unaffected by the next frame's weight load.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_last  <= col_last && row_last;
      out_data  <= {wt_flat, win_flat};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
